// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with branch/jump redirect and flush.
// Define EXMEM_SKID_EN for a 2-entry skid buffer with registered ex_ready.
module ex_mem_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_c,
  input  logic        alu_branch,
  input  logic [31:0] rD2_ex,
  input  logic [4:0]  wr_reg_ex,
  input  logic        rf_we_ex,
  input  logic        mem_we_ex,
  input  logic [1:0]  wd_sel_ex,
  input  logic [31:0] pc4_ex,
  input  logic        is_branch_ex,
  input  logic        is_jump_ex,
  input  logic [31:0] target_ex,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] alu_c_mem,
  output logic [31:0] rD2_mem,
  output logic [4:0]  wr_reg_mem,
  output logic        rf_we_mem,
  output logic        mem_we_mem,
  output logic [1:0]  wd_sel_mem,
  output logic [31:0] pc4_mem,
  input  logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef struct packed {
    logic [31:0] alu_c;
    logic [31:0] rd2;
    logic [4:0]  wr_reg;
    logic        rf_we;
    logic        mem_we;
    logic [1:0]  wd_sel;
    logic [31:0] pc4;
  } ent_t;

  ent_t        ex_ent;
  ent_t        head_q, head_d;
  logic        drop, accept, deliver, taken;
  logic        redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;

  assign ex_ent = {alu_c, rD2_ex, wr_reg_ex, rf_we_ex,
                   mem_we_ex, wd_sel_ex, pc4_ex};

  assign drop    = flush || redir_q;
  assign accept  = ex_valid && ex_ready && !drop;
  assign deliver = mem_valid && mem_ready;
  assign taken   = is_jump_ex || (is_branch_ex && alu_branch);

  assign alu_c_mem      = head_q.alu_c;
  assign rD2_mem        = head_q.rd2;
  assign wr_reg_mem     = head_q.wr_reg;
  assign rf_we_mem      = head_q.rf_we;
  assign mem_we_mem     = head_q.mem_we;
  assign wd_sel_mem     = head_q.wd_sel;
  assign pc4_mem        = head_q.pc4;
  assign redirect_valid = redir_q;
  assign redirect_pc    = rpc_q;

  // accept is already blocked by flush, so no redirect can follow one
  always_comb begin
    redir_d = accept && taken;
    rpc_d   = rpc_q;
    if (accept && taken) rpc_d = target_ex;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      head_q  <= head_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

`ifdef EXMEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  ent_t   tail_q, tail_d;
  logic   rdy_q, rdy_d;

  assign ex_ready  = rdy_q;
  assign mem_valid = (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = ex_ent;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          head_d = ex_ent;
        end else if (accept) begin
          state_d = TWO;
          tail_d  = ex_ent;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    // ready tracks the next state so it never depends on mem_ready combinationally
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      tail_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
    end
  end
`else
  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;

  assign mem_valid = (state_q == FULL);
  assign ex_ready  = !mem_valid || mem_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          head_d  = ex_ent;
        end
      end
      FULL: begin
        if (accept) head_d = ex_ent;
        else if (deliver) state_d = EMPTY;
      end
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed steps plus random traffic vs a queue model.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_c;
  logic        alu_branch;
  logic [31:0] rD2_ex;
  logic [4:0]  wr_reg_ex;
  logic        rf_we_ex;
  logic        mem_we_ex;
  logic [1:0]  wd_sel_ex;
  logic [31:0] pc4_ex;
  logic        is_branch_ex;
  logic        is_jump_ex;
  logic [31:0] target_ex;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] alu_c_mem;
  logic [31:0] rD2_mem;
  logic [4:0]  wr_reg_mem;
  logic        rf_we_mem;
  logic        mem_we_mem;
  logic [1:0]  wd_sel_mem;
  logic [31:0] pc4_mem;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic [104:0] mq[$];
  logic         m_rv;
  logic [31:0]  m_rpc;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_c(alu_c), .alu_branch(alu_branch),
    .rD2_ex(rD2_ex), .wr_reg_ex(wr_reg_ex),
    .rf_we_ex(rf_we_ex), .mem_we_ex(mem_we_ex),
    .wd_sel_ex(wd_sel_ex), .pc4_ex(pc4_ex),
    .is_branch_ex(is_branch_ex), .is_jump_ex(is_jump_ex),
    .target_ex(target_ex),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .alu_c_mem(alu_c_mem), .rD2_mem(rD2_mem),
    .wr_reg_mem(wr_reg_mem), .rf_we_mem(rf_we_mem),
    .mem_we_mem(mem_we_mem), .wd_sel_mem(wd_sel_mem),
    .pc4_mem(pc4_mem),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [104:0] obs,
                       input logic [104:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [104:0] ex_pack();
    return {alu_c, rD2_ex, wr_reg_ex, rf_we_ex,
            mem_we_ex, wd_sel_ex, pc4_ex};
  endfunction

  function automatic logic [104:0] mem_pack();
    return {alu_c_mem, rD2_mem, wr_reg_mem, rf_we_mem,
            mem_we_mem, wd_sel_mem, pc4_mem};
  endfunction

  function automatic logic m_ready();
    if (CAP == 2) return mq.size() < 2;
    return mq.size() == 0 || mem_ready;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic br, input logic ab,
                       input logic jmp, input logic [31:0] tgt);
    ex_valid     = v;
    alu_c        = a;
    is_branch_ex = br;
    alu_branch   = ab;
    is_jump_ex   = jmp;
    target_ex    = tgt;
    rD2_ex       = $urandom;
    wr_reg_ex    = 5'($urandom);
    rf_we_ex     = 1'($urandom);
    mem_we_ex    = 1'($urandom);
    wd_sel_ex    = 2'($urandom);
    pc4_ex       = $urandom;
  endtask

  // Check outputs mid-cycle, then advance the model across the next edge.
  task automatic cyc();
    logic rdy, acc, del, tk;
    @(negedge clk);
    rdy = m_ready();
    check("ex_ready", 105'(ex_ready), 105'(rdy));
    check("mem_valid", 105'(mem_valid), 105'(mq.size() != 0));
    check("redirect_valid", 105'(redirect_valid), 105'(m_rv));
    check("redirect_pc", 105'(redirect_pc), 105'(m_rpc));
    if (mq.size() != 0) check("mem_data", mem_pack(), mq[0]);
    acc = ex_valid && rdy && !(flush || m_rv);
    del = (mq.size() != 0) && mem_ready;
    tk  = is_jump_ex || (is_branch_ex && alu_branch);
    if (rst) begin
      mq.delete();
      m_rv  = 1'b0;
      m_rpc = '0;
    end else if (flush) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(ex_pack());
      m_rv = acc && tk;
      if (acc && tk) m_rpc = target_ex;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_rv  = 1'b0;
    m_rpc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_valid", 105'(mem_valid), 105'(0));
    check("rst_mem_data", mem_pack(), 105'(0));
    check("rst_redirect", 105'(redirect_valid), 105'(0));
    check("rst_rpc", 105'(redirect_pc), 105'(0));
    check("rst_ex_ready", 105'(ex_ready), 105'(1));
    @(posedge clk);
    #1;

    // four-beat stream with the sink always ready
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) cyc();

    // sink stalls for three cycles mid-stream
    for (int i = 5; i <= 12; i++) begin
      mem_ready = !(i >= 7 && i <= 9);
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) cyc();

    // taken branch, then a wrong-path entry during the redirect cycle
    drive(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h40);
    cyc();
    check("redir_taken", 105'(redirect_valid), 105'(1));
    check("redir_pc_40", 105'(redirect_pc), 105'(32'h40));
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) cyc();

    // not-taken branch, then jump with alu_branch low
    drive(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 32'h80);
    cyc();
    drive(1'b1, 32'h31, 1'b0, 1'b0, 1'b1, 32'hC0);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) cyc();

    // fill the buffer under stall, then flush against a jump
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(16'h50 + i), 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
    end
    flush = 1'b1;
    drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b1, 32'h100);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc();

    // reset while an entry is stalled at MEM
    drive(1'b1, 32'h70, 1'b0, 1'b0, 1'b1, 32'h200);
    cyc();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_data", mem_pack(), 105'(0));
    check("rst2_rpc", 105'(redirect_pc), 105'(0));
    cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      mem_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), $urandom);
      cyc();
    end
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    mem_ready = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
